// File: rtl/hex_digit_counter_pkg.sv
// rtl/hex_digit_counter_pkg.sv - shared constants for the hex/decimal digit counter
package hex_digit_counter_pkg;
    localparam int DIGIT_W      = 4;
    localparam int RADIX_HEX    = 16;
    localparam int RADIX_DEC    = 10;
    localparam int TICK_DIV_1HZ = 50000000;
endpackage

// File: rtl/hex_digit_cell.sv
// rtl/hex_digit_cell.sv - one counter digit with load clamp and carry/borrow chaining
module hex_digit_cell
    import hex_digit_counter_pkg::*;
#(
    parameter int RADIX = RADIX_HEX
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               adv,
    input  logic               up_down,
    input  logic               load,
    input  logic [DIGIT_W-1:0] ld_digit,
    input  logic               carry_in,
    output logic [DIGIT_W-1:0] digit,
    output logic               carry_out
);
    localparam logic [DIGIT_W-1:0] DIGIT_MAX = DIGIT_W'(RADIX - 1);

    logic               at_limit;
    logic [DIGIT_W-1:0] ld_clamped;

    // carry_in means every lower digit sits at its limit in the current direction
    assign at_limit   = up_down ? (digit == DIGIT_MAX) : (digit == '0);
    assign carry_out  = carry_in & at_limit;
    assign ld_clamped = (ld_digit > DIGIT_MAX) ? DIGIT_MAX : ld_digit;

    always_ff @(posedge clk) begin
        if (reset) begin
            digit <= '0;
        end else if (load) begin
            digit <= ld_clamped;
        end else if (adv && carry_in) begin
            if (up_down) begin
                digit <= (digit == DIGIT_MAX) ? '0 : digit + DIGIT_W'(1);
            end else begin
                digit <= (digit == '0) ? DIGIT_MAX : digit - DIGIT_W'(1);
            end
        end
    end
endmodule

// File: rtl/hex_digit_counter.sv
// rtl/hex_digit_counter.sv - multi-digit up/down counter feeding the seven-segment decoders
module hex_digit_counter
    import hex_digit_counter_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = TICK_DIV_1HZ,
    parameter int RADIX      = RADIX_HEX
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          en,
    input  logic                          auto_mode,
    input  logic                          up_down,
    input  logic                          step,
    input  logic                          load,
    input  logic [DIGIT_W*NUM_DIGITS-1:0] load_value,
    output logic [DIGIT_W*NUM_DIGITS-1:0] digits,
    output logic                          tick,
    output logic                          wrap
);
    localparam int              PW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

    logic [PW-1:0]         prescaler;
    logic                  step_q;
    logic                  step_rise;
    logic                  adv;
    logic [NUM_DIGITS:0]   chain;

    assign step_rise = step & ~step_q;
    assign adv       = en & ((auto_mode & tick) | (~auto_mode & step_rise));
    assign chain[0]  = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            tick      <= 1'b0;
            step_q    <= 1'b0;
            wrap      <= 1'b0;
        end else begin
            step_q <= step;
            // chain top set means every digit was at its limit, so this advance wraps
            wrap   <= ~load & adv & chain[NUM_DIGITS];
            if (load) begin
                prescaler <= '0;
                tick      <= 1'b0;
            end else if (en && auto_mode) begin
                if (prescaler == PRESC_MAX) begin
                    prescaler <= '0;
                    tick      <= 1'b1;
                end else begin
                    prescaler <= prescaler + PW'(1);
                    tick      <= 1'b0;
                end
            end else begin
                tick <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        hex_digit_cell #(.RADIX(RADIX)) u_cell (
            .clk       (clk),
            .reset     (reset),
            .adv       (adv),
            .up_down   (up_down),
            .load      (load),
            .ld_digit  (load_value[DIGIT_W*i +: DIGIT_W]),
            .carry_in  (chain[i]),
            .digit     (digits[DIGIT_W*i +: DIGIT_W]),
            .carry_out (chain[i+1])
        );
    end
endmodule

// File: tb/tb_hex_digit_counter.sv
// tb/tb_hex_digit_counter.sv - directed vector bench for hex_digit_counter
module tb_hex_digit_counter;
    logic        clk = 1'b0;
    logic        reset, en, auto_mode, up_down, step, load;
    logic [15:0] load_value;
    logic [15:0] hex_digits, dec_digits;
    logic        hex_tick, hex_wrap, dec_tick, dec_wrap;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hex_digit_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .RADIX(16)) dut_hex (
        .clk(clk), .reset(reset), .en(en), .auto_mode(auto_mode), .up_down(up_down),
        .step(step), .load(load), .load_value(load_value),
        .digits(hex_digits), .tick(hex_tick), .wrap(hex_wrap)
    );

    hex_digit_counter #(.NUM_DIGITS(4), .TICK_DIV(4), .RADIX(10)) dut_dec (
        .clk(clk), .reset(reset), .en(en), .auto_mode(auto_mode), .up_down(up_down),
        .step(step), .load(load), .load_value(load_value),
        .digits(dec_digits), .tick(dec_tick), .wrap(dec_wrap)
    );

    typedef struct {
        logic        rst, en, au, ud, st, ld;
        logic [15:0] lv;
        logic [15:0] exp_digits;
        logic        exp_tick, exp_wrap;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge
    task automatic drive(input logic r, input logic e, input logic a, input logic u,
                         input logic s, input logic l, input logic [15:0] v);
        @(negedge clk);
        reset = r; en = e; auto_mode = a; up_down = u; step = s; load = l; load_value = v;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; auto_mode = 1'b0; up_down = 1'b1;
        step = 1'b0; load = 1'b0; load_value = '0;

        //               rst en au ud st ld  lv        digits   tick wrap
        vecs.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0001,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0001,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0001,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0001,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0001,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0001,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,1'b1,16'hFFFE,16'hFFFE,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'hFFFF,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,16'hFFFF,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,16'h0000,16'h0000,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,16'h0000,16'hFFFF,1'b0,1'b1});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'hFFFF,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b1,1'b0,16'h0000,16'hFFFE,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,16'h0000,16'hFFFE,1'b0,1'b0});
        // load beats a simultaneous step edge; holding step afterwards gives no advance
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b1,16'h1234,16'h1234,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h1234,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h1234,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,1'b1,1'b0,1'b1,16'h5678,16'h0000,1'b0,1'b0});
        // step edge while disabled is dropped; the next real edge counts once
        vecs.push_back('{1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0000,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,16'h0000,16'h0000,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,16'h0000,16'h0001,1'b0,1'b0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].au, vecs[i].ud, vecs[i].st, vecs[i].ld, vecs[i].lv);
            chk($sformatf("vec%0d digits", i), 32'(hex_digits), 32'(vecs[i].exp_digits));
            chk($sformatf("vec%0d tick", i),   32'(hex_tick),   32'(vecs[i].exp_tick));
            chk($sformatf("vec%0d wrap", i),   32'(hex_wrap),   32'(vecs[i].exp_wrap));
        end

        // decimal radix
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        chk("dec reset", 32'(dec_digits), 32'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0999);
        chk("dec load 0999", 32'(dec_digits), 32'h0999);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000);
        chk("dec up 1000", 32'(dec_digits), 32'h1000);
        chk("dec up no wrap", 32'(dec_wrap), 32'h0);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00AB);
        chk("dec clamp 0099", 32'(dec_digits), 32'h0099);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1000);
        chk("dec load 1000", 32'(dec_digits), 32'h1000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("dec down 0999", 32'(dec_digits), 32'h0999);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
        chk("dec down wrap 9999", 32'(dec_digits), 32'h9999);
        chk("dec down wrap flag", 32'(dec_wrap), 32'h1);

        // auto mode: tick on every 4th edge, digit advance on the edge after it
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
        for (int k = 1; k <= 13; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("auto k%0d tick", k),   32'(hex_tick),   32'((k % 4) == 0));
            chk($sformatf("auto k%0d digits", k), 32'(hex_digits), 32'((k - 1) / 4));
        end
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("frozen c%0d tick", k),   32'(hex_tick),   32'h0);
            chk($sformatf("frozen c%0d digits", k), 32'(hex_digits), 32'h0003);
        end
        // prescaler held at 1, so the next tick lands on the 3rd enabled edge
        for (int k = 1; k <= 4; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
            chk($sformatf("resume k%0d tick", k),   32'(hex_tick),   32'(k == 3));
            chk($sformatf("resume k%0d digits", k), 32'(hex_digits), (k == 4) ? 32'h0004 : 32'h0003);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
